div_seq: RTL
============

# div_seq

Sequential restoring divider for the factorial datapath: the inverse operation to the adder chain, computing quotient and remainder of two unsigned `WIDTH`-bit operands. It produces one quotient bit per clock by shift-and-subtract, with each subtraction done as addition of the inverted divisor with carry-in 1. A start/done handshake lets the top-level controller launch a division and wait for the result. Typical uses are scaling factorial results and converting them to decimal digits (divide by 10).

## Interface
- `WIDTH`, 32, operand, quotient and remainder width in bits (≥ 2).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division; sampled only while `busy`=0.
- `dividend`  in  WIDTH  unsigned dividend, captured when `start` is accepted.
- `divisor`  in  WIDTH  unsigned divisor, captured when `start` is accepted.
- `busy`  out  1  division in progress.
- `done`  out  1  one-cycle pulse: results valid.
- `quotient`  out  WIDTH  unsigned quotient.
- `remainder`  out  WIDTH  unsigned remainder.
- `div_by_zero`  out  1  last accepted division had `divisor`=0.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
- Reset: state IDLE. `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, internal counter=0.
- Accept: `start`=1 and state IDLE at a rising edge. Operands are latched on that edge and never resampled afterwards.
- Zero divisor on accept:
  - State stays IDLE.
  - `quotient`=all ones, `remainder`=`dividend`, `div_by_zero`=1, `done`=1 for the next cycle.
- Nonzero divisor on accept:
  - Registers: R=0 (WIDTH+1 bits), Q=`dividend`, D=`divisor`, counter=WIDTH, `div_by_zero`=0.
  - State → RUN.
- Each RUN edge:
  - Form {R,Q} shifted left by 1. S = R_shifted + ~{0,D} + 1, computed at WIDTH+1 bits.
  - Carry-out 1 (no borrow): R=S, Q[0]=1.
  - Otherwise: R=R_shifted, Q[0]=0.
  - counter decrements by 1.
- Last iteration (counter reaches 0 on this edge):
  - State → IDLE.
  - `quotient`=Q, `remainder`=R[WIDTH-1:0].
  - `done`=1 for exactly one cycle.
- Output holding:
  - `quotient`, `remainder` and `div_by_zero` are registered.
  - They hold their values until the next completion or reset.
  - They do not change during RUN. Q and R are internal working registers, separate from the outputs.
- `start` while `busy`=1 is ignored. No queuing and no error flag.
- Invariant on `done`: `quotient`*`divisor`+`remainder`=`dividend` and `remainder`<`divisor`. Holds for all nonzero divisors, including `divisor`>`dividend` (q=0, r=dividend) and `dividend`=0.

## Timing
- `start` accepted at edge N (nonzero divisor):
  - `busy`=1 after edges N through N+WIDTH-1.
  - Last iteration at edge N+WIDTH. `busy` falls and `done` rises together after that edge.
  - Latency is WIDTH+1 edges from the accept edge to the end of the `done` cycle.
- Zero divisor: `done` high in the cycle right after the accept edge. `busy` never asserts.
- Back-to-back: `start` held high during the `done` cycle is accepted at the edge ending that cycle. Sustained throughput is one division per WIDTH+1 cycles.
- `reset` mid-RUN:
  - Aborts the division. All outputs return to reset values at that edge.
  - No `done` is produced.
  - `start` on the same edge as `reset` is ignored.
- `done` is never high for two consecutive cycles unless two zero-divisor starts are accepted on consecutive edges.

## Test plan
- Basic (WIDTH=32): reset, then `start` with 100/7 → `done` exactly 33 edges after the accept edge; `quotient`=14, `remainder`=2, `div_by_zero`=0. `busy` is high for exactly 32 cycles.
- Boundaries:
  - 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0.
  - 5/9 → q=0, r=5.
  - 0/3 → q=0, r=0.
  - 3628800/10 (10!) → q=362880, r=0.
- Divide by zero: 1234/0 → `done` one cycle after accept; q=0xFFFFFFFF, r=1234, `div_by_zero`=1, `busy` stays 0. A following 9/3 must give q=3, r=0 and clear `div_by_zero`.
- Handshake:
  - Pulse `start` again mid-RUN with different operands → ignored; the result is that of the first division.
  - Hold `start` high continuously across 720/6 and 50/7 → `done` pulses 33 cycles apart; results (120,0) then (7,1).
- Reset mid-operation: assert `reset` 10 cycles after accepting 1000/3 → all outputs 0 on the next cycle, no `done`. A fresh 1000/3 then gives q=333, r=1.
- Randomized self-check: 10,000 random operand pairs, including zero divisors, against a reference model of the `dividend` = q*`divisor` + r invariant.

Source files
------------

// File: rtl/div_seq_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The controller uses the master side and the divider uses the slave side.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_seq.sv
// Restoring shift-and-subtract divider: one quotient bit per clock.
// Each subtraction is an add of the inverted divisor with carry-in 1.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  div_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t r_state, w_state_nxt;

  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_r_sh;
  logic [WIDTH+1:0] w_sum;
  logic             w_carry;
  logic [WIDTH:0]   w_r_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_unused_msb;

  // R - D as R + ~{0,D} + 1; bit WIDTH+1 of the result is the carry-out.
  function automatic logic [WIDTH+1:0] trial_sub(input logic [WIDTH:0]   r_sh,
                                                 input logic [WIDTH-1:0] d);
    return {1'b0, r_sh} + {1'b0, ~{1'b0, d}} + (WIDTH+2)'(1);
  endfunction

  // R stays below D, so its top bit never feeds the shifted value.
  assign w_unused_msb = r_rem[WIDTH];
  assign w_r_sh       = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_sum        = trial_sub(w_r_sh, r_d);
  assign w_carry      = w_sum[WIDTH+1];
  assign w_r_nxt      = w_carry ? w_sum[WIDTH:0] : w_r_sh;
  assign w_q_nxt      = {r_q[WIDTH-2:0], w_carry};

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.start && (bus.divisor != '0)) w_state_nxt = S_RUN;
      S_RUN:  if (r_cnt == CW'(1))                  w_state_nxt = S_IDLE;
      default:                                      w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (r_state == S_RUN);
    bus.done        = r_done;
    bus.quotient    = r_quot;
    bus.remainder   = r_remo;
    bus.div_by_zero = r_dbz;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (bus.divisor == '0) begin
          r_quot <= '1;
          r_remo <= bus.dividend;
          r_dbz  <= 1'b1;
          r_done <= 1'b1;
        end else begin
          r_rem <= '0;
          r_q   <= bus.dividend;
          r_d   <= bus.divisor;
          r_cnt <= CW'(WIDTH);
          r_dbz <= 1'b0;
        end
      end else if (r_state == S_RUN) begin
        r_rem <= w_r_nxt;
        r_q   <= w_q_nxt;
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          r_quot <= w_q_nxt;
          r_remo <= w_r_nxt[WIDTH-1:0];
          r_done <= 1'b1;
        end
      end
    end
  end
endmodule
